// File: rtl/sfr_timer_pkg.sv
// Register map, channel layout and CTRL encoding shared by the SFR timer bank
// and its channels.
package sfr_timer_pkg;

    localparam logic [7:0] REG_IDCODE   = 8'h00;
    localparam logic [7:0] REG_IRQ_PEND = 8'h04;
    localparam logic [7:0] REG_IRQ_MASK = 8'h08;
    localparam logic [7:0] REG_CFG      = 8'h0C;

    localparam logic [7:0] CHAN_BASE    = 8'h40;
    localparam logic [7:0] CHAN_STRIDE  = 8'h10;

    localparam logic [7:0] CH_CTRL      = 8'h0;
    localparam logic [7:0] CH_PERIOD    = 8'h4;
    localparam logic [7:0] CH_VALUE     = 8'h8;
    localparam logic [7:0] CH_PRESC     = 8'hC;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_RELOAD  = 1;
    localparam int CTRL_CASCADE = 2;

    typedef struct packed {
        logic cascade;
        logic reload;
        logic en;
    } ctrl_t;

    function automatic logic [7:0] chan_addr(input int k, input logic [7:0] off);
        return 8'(int'(CHAN_BASE) + int'(CHAN_STRIDE) * k + int'(off));
    endfunction

endpackage

// File: rtl/mem_split32.sv
// MemSplit32 register bus: combinational ack, reads answered by a one-cycle
// resp pulse with registered rdata, writes have no response.
interface MemSplit32;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        ack;
    logic        resp;
    logic [31:0] rdata;

    modport Master (output req, we, addr, wdata, be, input ack, resp, rdata);
    modport Slave  (input req, we, addr, wdata, be, output ack, resp, rdata);
endinterface

// File: rtl/sfr_timer_ch.sv
// One timer channel: prescaler, 32-bit up-counter with PERIOD compare and expiry
// pulse. Chaining from the previous channel exists only with SFR_TIMER_CASCADE_EN.
module sfr_timer_ch
    import sfr_timer_pkg::*;
#(
    parameter int PRESC_W = 16,
    parameter bit CASC_OK = 1'b1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               ctrl_we_i,
    input  logic               period_we_i,
    input  logic               presc_we_i,
    input  logic [31:0]        wdata_i,
    input  logic               cascade_tick_i,
    output ctrl_t              ctrl_o,
    output logic [31:0]        period_o,
    output logic [31:0]        value_o,
    output logic [PRESC_W-1:0] presc_o,
    output logic               expire_o
);

    ctrl_t              r_ctrl;
    logic [31:0]        r_period;
    logic [31:0]        r_value;
    logic [PRESC_W-1:0] r_presc;
    logic [PRESC_W-1:0] r_pc;

    logic               w_pc_hit;
    logic               w_tick;
    logic               w_wrap_hit;
    logic [31:0]        w_value_inc;

    assign w_pc_hit    = (r_pc == r_presc);
    assign w_value_inc = r_value + 32'd1;
    // PERIOD=0 matches only on the FFFFFFFF->0 wrap, giving a 2^32-tick period.
    assign w_wrap_hit  = (w_value_inc == r_period);

`ifdef SFR_TIMER_CASCADE_EN
    logic w_casc_sel;
    assign w_casc_sel = CASC_OK && r_ctrl.cascade;
    assign w_tick     = w_casc_sel ? cascade_tick_i : w_pc_hit;
`else
    logic w_unused;
    assign w_unused = cascade_tick_i ^ CASC_OK;
    assign w_tick   = w_pc_hit;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_ctrl   <= '0;
            r_period <= '0;
            r_value  <= '0;
            r_presc  <= '0;
            r_pc     <= '0;
        end else begin
            if (period_we_i) begin
                r_period <= wdata_i;
            end
            if (presc_we_i) begin
                r_presc <= wdata_i[PRESC_W-1:0];
            end
            // A CTRL write restarts the count and overrides a coinciding tick.
            if (ctrl_we_i) begin
                r_ctrl.en     <= wdata_i[CTRL_EN];
                r_ctrl.reload <= wdata_i[CTRL_RELOAD];
`ifdef SFR_TIMER_CASCADE_EN
                r_ctrl.cascade <= wdata_i[CTRL_CASCADE];
`else
                r_ctrl.cascade <= 1'b0;
`endif
                r_value <= '0;
                r_pc    <= '0;
            end else if (r_ctrl.en) begin
                r_pc <= w_pc_hit ? '0 : r_pc + PRESC_W'(1);
                if (w_tick) begin
                    if (w_wrap_hit) begin
                        r_value   <= '0;
                        r_ctrl.en <= r_ctrl.reload;
                    end else begin
                        r_value <= w_value_inc;
                    end
                end
            end
        end
    end

    assign expire_o = r_ctrl.en & w_tick & w_wrap_hit;
    assign ctrl_o   = r_ctrl;
    assign period_o = r_period;
    assign value_o  = r_value;
    assign presc_o  = r_presc;

endmodule

// File: rtl/sfr_timer_bank.sv
// Bank of N_TIMERS SFR timers on a MemSplit32 slave: decode, read mux, W1C pend,
// mask and IRQ lines. Channel chaining is built only with SFR_TIMER_CASCADE_EN.
module sfr_timer_bank
    import sfr_timer_pkg::*;
#(
    parameter int          N_TIMERS = 4,
    parameter int          PRESC_W  = 16,
    parameter logic [31:0] IDCODE   = 32'h71AE0001
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    MemSplit32.Slave            host,
    output logic [N_TIMERS-1:0] irq_bo,
    output logic                irq_o
);

    logic [7:0]          w_addr;
    logic                w_wr;
    logic                w_rd;
    logic                w_unused;
    logic [N_TIMERS-1:0] w_expire;
    logic [N_TIMERS-1:0] w_casc_tick;
    logic [N_TIMERS-1:0] w_ctrl_we;
    logic [N_TIMERS-1:0] w_period_we;
    logic [N_TIMERS-1:0] w_presc_we;
    logic [N_TIMERS-1:0] w_pend_clr;
    ctrl_t               w_ctrl   [N_TIMERS];
    logic [31:0]         w_period [N_TIMERS];
    logic [31:0]         w_value  [N_TIMERS];
    logic [PRESC_W-1:0]  w_presc  [N_TIMERS];
    logic [31:0]         w_rdata;

    logic [N_TIMERS-1:0] r_pend;
    logic [N_TIMERS-1:0] r_mask;
    logic                r_resp;
    logic [31:0]         r_rdata;

    assign w_addr   = host.addr[7:0];
    assign w_wr     = host.req & host.we;
    assign w_rd     = host.req & ~host.we;
    assign w_unused = ^{host.addr[31:8], host.be};

    assign host.ack   = host.req;
    assign host.resp  = r_resp;
    assign host.rdata = r_rdata;

    for (genvar k = 0; k < N_TIMERS; k++) begin : g_ch
        assign w_ctrl_we[k]   = w_wr && (w_addr == chan_addr(k, CH_CTRL));
        assign w_period_we[k] = w_wr && (w_addr == chan_addr(k, CH_PERIOD));
        assign w_presc_we[k]  = w_wr && (w_addr == chan_addr(k, CH_PRESC));

        if (k == 0) begin : g_first
            assign w_casc_tick[k] = 1'b0;
        end else begin : g_chain
            assign w_casc_tick[k] = w_expire[k-1];
        end

        sfr_timer_ch #(
            .PRESC_W (PRESC_W),
            .CASC_OK (k != 0)
        ) u_ch (
            .clk_i          (clk_i),
            .rst_ni         (rst_ni),
            .ctrl_we_i      (w_ctrl_we[k]),
            .period_we_i    (w_period_we[k]),
            .presc_we_i     (w_presc_we[k]),
            .wdata_i        (host.wdata),
            .cascade_tick_i (w_casc_tick[k]),
            .ctrl_o         (w_ctrl[k]),
            .period_o       (w_period[k]),
            .value_o        (w_value[k]),
            .presc_o        (w_presc[k]),
            .expire_o       (w_expire[k])
        );
    end

    always_comb begin
        w_rdata = '0;
        case (w_addr)
            REG_IDCODE:   w_rdata = IDCODE;
            REG_IRQ_PEND: w_rdata = 32'(r_pend);
            REG_IRQ_MASK: w_rdata = 32'(r_mask);
            REG_CFG:      w_rdata = {16'h0, 8'(PRESC_W), 8'(N_TIMERS)};
            default:      w_rdata = '0;
        endcase
        for (int k = 0; k < N_TIMERS; k++) begin
            if (w_addr == chan_addr(k, CH_CTRL))   w_rdata = 32'(w_ctrl[k]);
            if (w_addr == chan_addr(k, CH_PERIOD)) w_rdata = w_period[k];
            if (w_addr == chan_addr(k, CH_VALUE))  w_rdata = w_value[k];
            if (w_addr == chan_addr(k, CH_PRESC))  w_rdata = 32'(w_presc[k]);
        end
    end

    assign w_pend_clr = (w_wr && (w_addr == REG_IRQ_PEND)) ? host.wdata[N_TIMERS-1:0] : '0;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_pend  <= '0;
            r_mask  <= '0;
            r_resp  <= 1'b0;
            r_rdata <= '0;
        end else begin
            // Hardware set wins over a same-cycle W1C of the same bit.
            r_pend <= (r_pend & ~w_pend_clr) | w_expire;
            if (w_wr && (w_addr == REG_IRQ_MASK)) begin
                r_mask <= host.wdata[N_TIMERS-1:0];
            end
            r_resp <= w_rd;
            if (w_rd) begin
                r_rdata <= w_rdata;
            end
        end
    end

    assign irq_bo = r_pend & r_mask;
    assign irq_o  = |irq_bo;

endmodule

// File: tb/tb_sfr_timer_bank.sv
// Self-checking bench for sfr_timer_bank: directed register-map/timing checks
// with literal expectations, then random bus traffic against a register-level model.
module tb_sfr_timer_bank;

    localparam int          N  = 4;
    localparam int          PW = 16;
    localparam logic [31:0] ID = 32'h71AE0001;

    logic         clk_i  = 1'b0;
    logic         rst_ni = 1'b0;
    logic [N-1:0] irq_bo;
    logic         irq_o;

    MemSplit32 bus();

    always #5 clk_i = ~clk_i;

    sfr_timer_bank #(
        .N_TIMERS (N),
        .PRESC_W  (PW),
        .IDCODE   (ID)
    ) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .host   (bus),
        .irq_bo (irq_bo),
        .irq_o  (irq_o)
    );

    int n_chk = 0;
    int n_err = 0;
    bit chk_on = 1'b0;

    // Register-level model state
    int unsigned m_value  [N];
    int unsigned m_period [N];
    int unsigned m_presc  [N];
    int unsigned m_pc     [N];
    bit          m_en     [N];
    bit          m_rel    [N];
    bit          m_cas    [N];
    bit [N-1:0]  m_pend;
    bit [N-1:0]  m_mask;
    bit          m_resp;
    logic [31:0] m_rdata;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [7:0] a);
        int k;
        int off;
        case (a)
            8'h00:   return ID;
            8'h04:   return 32'(m_pend);
            8'h08:   return 32'(m_mask);
            8'h0C:   return 32'((PW << 8) | N);
            default: ;
        endcase
        if (a < 8'h40) return 32'd0;
        k   = (int'(a) - 64) / 16;
        off = int'(a) % 16;
        if (k >= N) return 32'd0;
        case (off)
            0:       return {29'd0, m_cas[k], m_rel[k], m_en[k]};
            4:       return m_period[k];
            8:       return m_value[k];
            12:      return m_presc[k];
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_step();
        bit          own  [N];
        bit          tick [N];
        bit [N-1:0]  fire;
        bit [N-1:0]  clr;
        bit          wr;
        bit          rd;
        logic [7:0]  a;
        logic [31:0] d;
        if (!rst_ni) begin
            for (int k = 0; k < N; k++) begin
                m_value[k] = 0; m_period[k] = 0; m_presc[k] = 0; m_pc[k] = 0;
                m_en[k] = 0; m_rel[k] = 0; m_cas[k] = 0;
            end
            m_pend = '0; m_mask = '0; m_resp = 0; m_rdata = '0;
            return;
        end
        wr = bus.req && bus.we;
        rd = bus.req && !bus.we;
        a  = bus.addr[7:0];
        d  = bus.wdata;
        if (rd) m_rdata = m_read(a);
        m_resp = rd;
        fire = '0;
        for (int k = 0; k < N; k++) begin
            own[k] = (m_pc[k] == m_presc[k]);
`ifdef SFR_TIMER_CASCADE_EN
            tick[k] = (k > 0 && m_cas[k]) ? fire[k-1] : own[k];
`else
            tick[k] = own[k];
`endif
            fire[k] = m_en[k] && tick[k] && ((m_value[k] + 32'd1) == m_period[k]);
        end
        for (int k = 0; k < N; k++) begin
            if (wr && a == 8'(64 + 16 * k)) begin
                m_en[k]  = d[0];
                m_rel[k] = d[1];
`ifdef SFR_TIMER_CASCADE_EN
                m_cas[k] = d[2];
`else
                m_cas[k] = 1'b0;
`endif
                m_value[k] = 0;
                m_pc[k]    = 0;
            end else if (m_en[k]) begin
                m_pc[k] = own[k] ? 0 : ((m_pc[k] + 1) & ((1 << PW) - 1));
                if (tick[k]) begin
                    if (fire[k]) begin
                        m_value[k] = 0;
                        m_en[k]    = m_rel[k];
                    end else begin
                        m_value[k] = m_value[k] + 32'd1;
                    end
                end
            end
            if (wr && a == 8'(68 + 16 * k)) m_period[k] = d;
            if (wr && a == 8'(76 + 16 * k)) m_presc[k]  = d & ((1 << PW) - 1);
        end
        clr    = (wr && a == 8'h04) ? d[N-1:0] : '0;
        m_pend = (m_pend & ~clr) | fire;
        if (wr && a == 8'h08) m_mask = d[N-1:0];
    endtask

    always @(posedge clk_i) model_step();

    always @(negedge clk_i) begin
        if (chk_on) begin
            check("ack", 32'(bus.ack), 32'(bus.req));
            check("resp", 32'(bus.resp), 32'(m_resp));
            if (m_resp) check("rdata", bus.rdata, m_rdata);
            check("irq_bo", 32'(irq_bo), 32'(m_pend & m_mask));
            check("irq_o", 32'(irq_o), 32'(|(m_pend & m_mask)));
        end
    end

    task automatic step();
        @(posedge clk_i);
        #2;
    endtask

    task automatic bus_idle();
        bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0; bus.be = '0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        bus.req = 1'b1; bus.we = 1'b1; bus.addr = {24'($urandom), a};
        bus.wdata = d; bus.be = 4'($urandom);
        step();
        bus_idle();
    endtask

    task automatic rd(input logic [7:0] a, output logic [31:0] d);
        bus.req = 1'b1; bus.we = 1'b0; bus.addr = {24'($urandom), a};
        bus.wdata = $urandom; bus.be = 4'hF;
        step();
        bus_idle();
        check("rd_resp", 32'(bus.resp), 32'd1);
        d = bus.rdata;
    endtask

    task automatic rd_exp(input string name, input logic [7:0] a, input logic [31:0] exp);
        logic [31:0] d;
        rd(a, d);
        check(name, d, exp);
    endtask

    initial begin
        logic [31:0] d;
        int          op;
        int          k;
        logic [7:0]  base;

        bus_idle();
        rst_ni = 1'b0;
        step();
        step();
        rst_ni = 1'b1;
        chk_on = 1'b1;
        check("rst_irq_o", 32'(irq_o), 32'd0);
        check("rst_irq_bo", 32'(irq_bo), 32'd0);
        check("rst_resp", 32'(bus.resp), 32'd0);
        check("rst_rdata", bus.rdata, 32'd0);

        rd_exp("idcode", 8'h00, 32'h71AE0001);
        rd_exp("cfg", 8'h0C, 32'h00001004);
        rd_exp("unmapped_3c", 8'h3C, 32'd0);
        rd_exp("unmapped_ch4", 8'h84, 32'd0);

        // One-shot on ch0: expiry 5 cycles after the CTRL write edge
        wr(8'h44, 32'd5); wr(8'h4C, 32'd0); wr(8'h08, 32'd1); wr(8'h40, 32'd1);
        for (int t = 1; t <= 5; t++) begin
            step();
            check("ch0_irq_timing", 32'(irq_o), 32'(t == 5));
        end
        rd_exp("ch0_en_cleared", 8'h40, 32'd0);
        rd_exp("ch0_value_zero", 8'h48, 32'd0);
        rd_exp("ch0_pend", 8'h04, 32'd1);
        wr(8'h04, 32'd1);
        check("ch0_w1c", 32'(irq_o), 32'd0);

        // Auto-reload on ch1: period 3 x (2+1) = 9 cycles
        wr(8'h54, 32'd3); wr(8'h5C, 32'd2); wr(8'h08, 32'd2); wr(8'h50, 32'd3);
        for (int t = 1; t <= 9; t++) begin
            step();
            check("ch1_irq_timing", 32'(irq_bo[1]), 32'(t == 9));
        end
        step(); step();
        wr(8'h04, 32'd2);
        check("ch1_w1c", 32'(irq_bo[1]), 32'd0);
        repeat (5) step();
        wr(8'h04, 32'd2);
        check("ch1_set_beats_clr", 32'(irq_bo[1]), 32'd1);
        wr(8'h04, 32'd2);
        check("ch1_clr_after", 32'(irq_bo[1]), 32'd0);
        repeat (8) step();
        check("ch1_third_expiry", 32'(irq_bo[1]), 32'd1);
        wr(8'h50, 32'd0); wr(8'h04, 32'd2);

        // Pend is set regardless of mask on ch2
        wr(8'h64, 32'd2); wr(8'h6C, 32'd0); wr(8'h08, 32'd0); wr(8'h60, 32'd1);
        step(); step(); step();
        check("ch2_masked", 32'(irq_o), 32'd0);
        rd_exp("ch2_pend", 8'h04, 32'd4);
        wr(8'h08, 32'd4);
        check("ch2_unmask_irq_o", 32'(irq_o), 32'd1);
        check("ch2_unmask_irq_bo", 32'(irq_bo), 32'd4);
        wr(8'h04, 32'd4); wr(8'h08, 32'd0);
        wr(8'h60, 32'd4);
`ifdef SFR_TIMER_CASCADE_EN
        rd_exp("ch2_cascade_bit", 8'h60, 32'd4);
`else
        rd_exp("ch2_cascade_bit", 8'h60, 32'd0);
`endif
        wr(8'h60, 32'd0);

        // Reset in the middle of a ch0 count
        wr(8'h44, 32'd5); wr(8'h4C, 32'd0); wr(8'h08, 32'd1); wr(8'h40, 32'd1);
        step(); step();
        rd_exp("ch0_value_mid", 8'h48, 32'd2);
        rst_ni = 1'b0;
        step();
        rst_ni = 1'b1;
        rd_exp("rst_ctrl", 8'h40, 32'd0);
        rd_exp("rst_period", 8'h44, 32'd0);
        rd_exp("rst_value", 8'h48, 32'd0);
        rd_exp("rst_presc", 8'h4C, 32'd0);
        rd_exp("rst_mask", 8'h08, 32'd0);
        rd_exp("rst_pend", 8'h04, 32'd0);
        repeat (8) begin
            step();
            check("rst_no_irq", 32'(irq_o), 32'd0);
        end

`ifdef SFR_TIMER_CASCADE_EN
        // ch1 counts ch0 expiries: 3 x 2 = 6 cycles
        wr(8'h44, 32'd2); wr(8'h4C, 32'd0); wr(8'h54, 32'd3); wr(8'h08, 32'd2);
        wr(8'h50, 32'd5); wr(8'h40, 32'd3);
        for (int t = 1; t <= 6; t++) begin
            step();
            check("cascade_timing", 32'(irq_bo[1]), 32'(t == 6));
        end
        wr(8'h40, 32'd0); wr(8'h50, 32'd0); wr(8'h04, 32'hF); wr(8'h08, 32'd0);
`endif

        // Random traffic, checked every cycle against the model
        for (int i = 0; i < 3000; i++) begin
            op   = int'($urandom_range(0, 99));
            k    = int'($urandom_range(0, N));
            base = 8'(64 + 16 * k);
            if (op < 14)      wr(base, 32'($urandom_range(0, 7)));
            else if (op < 24) wr(base + 8'h4, 32'($urandom_range(0, 12)));
            else if (op < 31) wr(base + 8'hC, 32'($urandom_range(0, 3)));
            else if (op < 37) wr(8'h08, $urandom);
            else if (op < 43) wr(8'h04, $urandom);
            else if (op < 45) wr(8'($urandom), $urandom);
            else if (op < 60) rd(base + 8'(4 * $urandom_range(0, 3)), d);
            else if (op < 68) rd(8'(4 * $urandom_range(0, 3)), d);
            else if (op < 71) rd(8'($urandom), d);
            else if (op < 72) begin
                rst_ni = 1'b0;
                step();
                rst_ni = 1'b1;
            end else begin
                step();
            end
        end

        bus_idle();
        step();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/sfr_timer_bank.md
Name: sfr_timer_bank

Overview:
- Parametrised successor to the tile special-function-register timer.
- Provides N_TIMERS independent 32-bit timers, each with its own prescaler, one-shot/auto-reload mode and IRQ enable.
- Adds a global write-1-to-clear IRQ pending register and a mask register.
- Sits on the tile's MemSplit32 slave bus beside the core SFR block and drives per-timer interrupt lines into the tile IRQ controller.

Parameters:
- N_TIMERS, 4, number of timer channels (1..8).
- PRESC_W, 16, prescaler counter/register width in bits (1..32).
- IDCODE, 32'h71AE0001, value returned at IDCODE register.

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  reset, synchronous, active-low.
- host  MemSplit32.Slave  -  register bus: req, we, addr, wdata, be, ack, resp, rdata.
- irq_bo  output  N_TIMERS  per-channel interrupt = pending & mask.
- irq_o  output  1  OR-reduction of irq_bo.

Behaviour:
- Address decode on host.addr[7:0].
  - Global registers: 0x00 IDCODE (RO); 0x04 IRQ_PEND (W1C); 0x08 IRQ_MASK (RW); 0x0C CFG (RO) = {PRESC_W[7:0] at bits 15:8, N_TIMERS at bits 7:0}.
  - Channel k registers, base 0x40+0x10*k: +0 CTRL (bit0 EN, bit1 RELOAD, bit2 CASCADE); +4 PERIOD (RW); +8 VALUE (RO); +C PRESCALE (RW, PRESC_W bits, zero-extended on read).
  - Decodes for k >= N_TIMERS are unmapped.
- Bus handshake:
  - host.ack = host.req, combinational.
  - Reads: host.resp pulses for 1 cycle, the cycle after req&!we; rdata registered in that same edge. Unmapped reads return 0.
  - Writes: no resp; take effect on the next edge; unmapped writes ignored. host.be ignored (full-word writes).
- Reset (rst_ni=0 at edge):
  - All CTRL, PERIOD, VALUE, PRESCALE, prescale counters, IRQ_PEND and IRQ_MASK cleared to 0.
  - resp=0, rdata=0, irq_bo=0, irq_o=0.
  - Reset asserted mid-count aborts the count with no IRQ.
- Per-channel counting, when EN=1:
  - Prescale counter pc increments each cycle.
  - When pc==PRESCALE: tick, and pc<=0. PRESCALE=0 gives a tick every cycle.
- On tick:
  - If VALUE+1 == PERIOD (32-bit, wrapping): VALUE<=0, pend[k]<=1, EN<=RELOAD.
  - Else VALUE<=VALUE+1.
  - PERIOD=0 means expiry on wrap FFFFFFFF->0, i.e. a 2^32-tick period.
  - Expiry interval = PERIOD*(PRESCALE+1) cycles after enable.
- Write to CTRL (any value): VALUE<=0 and pc<=0 in the same edge. The write has priority over a coinciding tick or expiry for that channel's VALUE/EN, but an expiry in that cycle still sets pend.
- Write to PERIOD while running: takes effect immediately. If VALUE already >= new PERIOD, the counter runs to wrap (2^32 ticks).
- EN=0: VALUE and pc hold.
- IRQ_PEND:
  - Write 1 clears the corresponding bit.
  - A hardware set in the same cycle as a clear of the same bit wins (bit stays 1).
  - Pend bits are set regardless of mask.
- Outputs: irq_bo = pend & mask, combinational from registers (1-cycle after the expiry edge). irq_o = |irq_bo.
- Bits above N_TIMERS in PEND/MASK read 0 and ignore writes.

Optional Feature:
- Macro: SFR_TIMER_CASCADE_EN.
- Defined:
  - For k>0 with CTRL.CASCADE=1, the channel's tick is channel k-1's expiry pulse instead of its prescaler; its own PRESCALE is ignored. This forms a 64-bit+ chained counter.
  - CASCADE on channel 0 is ignored (reads back as written).
  - An expiry of k-1 while channel k is disabled is lost.
- Undefined: CTRL bit2 is not stored, reads 0, and the channel always uses its prescaler.

Decomposition:
- Package sfr_timer_pkg holds:
  - global register offsets;
  - CHAN_BASE (0x40) and CHAN_STRIDE (0x10);
  - channel register offsets;
  - CTRL bit indices;
  - a packed struct for CTRL.
- Sub-module sfr_timer_ch, instantiated N_TIMERS times via generate:
  - contains the prescaler, VALUE, EN/RELOAD/CASCADE state and expiry pulse output;
  - takes ctrl_we/period_we/presc_we strobes, wdata and cascade_tick_i.
- Top level holds: bus decode, read mux, PEND/MASK, IRQ outputs.

Test Plan:
- Reset, then read 0x00, 0x0C -> IDCODE value, then 0x00001004 (PRESC_W=16, N=4). resp is 1 cycle after req. Read 0x3C -> 0.
- Ch0: PERIOD=5, PRESCALE=0, MASK=1, CTRL=1 -> pend[0] and irq_o rise 5 cycles after the write edge. EN reads 0 afterwards; VALUE holds 0.
- Ch1: PERIOD=3, PRESCALE=2, CTRL=3 (reload) -> an IRQ every 9 cycles repeatedly.
  - W1C 0x04=2 clears it.
  - A clear issued in the expiry cycle leaves pend[1]=1.
- Ch2: CTRL=1 with MASK=0 -> pend[2]=1 but irq_bo[2]=0. Then MASK=4 -> irq_o asserts the next cycle.
- Assert rst_ni=0 for 1 cycle while ch0 is at VALUE=3 of 5 -> all registers 0, no IRQ afterwards.
- With SFR_TIMER_CASCADE_EN defined:
  - ch0 PERIOD=2 reload; ch1 CASCADE|EN with PERIOD=3 -> ch1 expires after 6 cycles.
  - Without the macro, CTRL bit2 reads 0.
